lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
Parametrised load/store controller for the execute stage. It is the successor to the fixed 32-bit memory access controller and read-data formatter pair, and merges both into one block. Adds:
- configurable XLEN (32/64)
- a memory ready handshake with variable wait states
- automatic splitting of accesses that cross an XLEN-word boundary into two beats
Sits between the execute stage (effective address, store data) and the data port of the RAM, and returns formatted load data to the memory/writeback stage.

Parameters:
XLEN, 32, data width; legal values 32 or 64; BYTES = XLEN/8, OFS_W = log2(BYTES)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_addr  in  ADDR_W  effective byte address (rs1+imm)
in_data  in  XLEN  store data, LSB-aligned
len  in  2  0=byte 1=half 2=word 3=dword (dword is treated as word when XLEN=32)
uns  in  1  zero-extend load result
load  in  1  load request
store  in  1  store request; if load and store are both high, the access is a load
mem_req  out  1  memory access valid
mem_addr  out  ADDR_W  XLEN-aligned address (low OFS_W bits zero)
mem_w_data  out  XLEN  store data lane-aligned
mem_we  out  BYTES  byte write strobes; all zero for loads
mem_ready  in  1  memory accepts beat when mem_req&mem_ready
mem_r_data  in  XLEN  read data, valid the cycle after the beat is accepted
ld_data  out  XLEN  formatted load result
ld_valid  out  1  one-cycle pulse, ld_data valid
stall  out  1  holds the upstream pipeline; upstream keeps in_* stable while high
misalign  out  1  misaligned-access pulse (optional feature only)

Behaviour:
- Reset: state=IDLE; mem_req, mem_we, stall, ld_valid, misalign all 0; ld_data, mem_addr, mem_w_data all 0.
- Reset mid-access aborts. No ld_valid is produced and no further beats are issued.
- ofs = in_addr[OFS_W-1:0]; size = 1<<len.
- split = (ofs+size > BYTES).
- Store data: shifted = {XLEN'0,in_data} << 8*ofs (2*XLEN wide). Beat 1 uses the low half; beat 2 uses the high half.
- Strobes: the mask of bytes ofs .. ofs+size-1 across 2*BYTES. The low BYTES bits go to beat 1; the high BYTES bits go to beat 2.
- FSM states:
  - IDLE: when load|store, mem_req=1 and mem_addr=aligned(in_addr).
    - Not split: stall=~mem_ready.
    - Split: stall=1; on mem_ready, latch aligned addr, upper strobes/data, ofs, len, uns, load into regs; go to SECOND.
  - SECOND: mem_req=1, mem_addr=latched+BYTES, upper strobes/data from regs, stall=~mem_ready. On mem_ready, go to IDLE.
- Beat-1 read data: captured into hold buffer lo_buf in the first cycle after beat-1 acceptance, exactly once (capture flag).
- Response register: loaded on the final-beat acceptance of a load with {ofs, len, uns, split}.
  - Next cycle: ld_valid=1.
  - ld_data = sign/zero-extend of bytes taken from (split ? {mem_r_data, lo_buf} : {XLEN'0, mem_r_data}) >> 8*ofs.
- Latency:
  - Aligned access with ready=1: zero stall cycles; ld_valid 1 cycle after the request.
  - Split access with ready=1: 1 stall cycle; ld_valid 1 cycle after the second beat.
- Back-to-back accesses are allowed with no bubble. The response register and a new beat acceptance coexist.
- Stores never pulse ld_valid.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: any access with ofs not a multiple of size issues no mem_req. misalign pulses for 1 cycle, stall=0, no ld_valid. SECOND state and lo_buf are compiled out.
- Undefined: misalign is tied 0 and split handling is as above.

Decomposition:
- Shared package lsu_pkg holds:
  - LEN_B/LEN_H/LEN_W/LEN_D encodings
  - state enum IDLE/SECOND
  - function for the byte-mask of (ofs,len)
- Natural sub-module: lsu_rdata_fmt, a combinational shift plus sign/zero-extend of the 2*XLEN window.

Test Plan:
1. Aligned word store, addr 0x100, data 0xDEADBEEF, ready=1 -> one beat: mem_addr=0x100, mem_we=0xF, stall=0.
2. Word load at 0x103; mem[0x100]=0x44332211, mem[0x104]=0x88776655 -> beats at 0x100 then 0x104, stall high 1 cycle, ld_data=0x77665544.
3. Halfword store at 0x1007, data 0xABCD -> beat 1: addr 0x1004, we=0x8, w_data[31:24]=0xCD. Beat 2: addr 0x1008, we=0x1, w_data[7:0]=0xAB.
4. Byte load at 0x202, word 0x00800000 -> uns=0 gives ld_data=0xFFFFFF80; uns=1 gives 0x00000080.
5. Aligned load with mem_ready low for 3 cycles -> stall high 3 cycles, mem_addr stable, ld_valid exactly 1 cycle after the ready cycle.
6. rst asserted in SECOND -> next cycle mem_req=0, stall=0, and no ld_valid ever. With LSU_MISALIGN_TRAP_EN, word load at 0x103 -> misalign=1 for 1 cycle, mem_req=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store controller.
// Access-size codes, FSM state type and the byte-lane mask helper.
package lsu_pkg;

   localparam logic [1:0] LEN_B = 2'd0;
   localparam logic [1:0] LEN_H = 2'd1;
   localparam logic [1:0] LEN_W = 2'd2;
   localparam logic [1:0] LEN_D = 2'd3;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_SECOND = 1'b1
   } lsu_state_e;

   // Bytes ofs .. ofs+size-1 set, over a window of up to 16 lanes.
   function automatic logic [15:0] byte_mask(
      input logic [2:0] ofs,
      input logic [1:0] len
   );
      logic [15:0] m;
      m = (16'd1 << (4'd1 << len)) - 16'd1;
      return m << ofs;
   endfunction

endpackage

// File: rtl/lsu_rdata_fmt.sv
// Load data formatter: shifts the two-word read window down by the
// byte offset, then sign- or zero-extends to the access size.
module lsu_rdata_fmt #(
   parameter int XLEN  = 32,
   parameter int OFS_W = 2
) (
   input  logic [2*XLEN-1:0] win,
   input  logic [OFS_W-1:0]  ofs,
   input  logic [1:0]        len,
   input  logic              uns,
   output logic [XLEN-1:0]   data
);
   import lsu_pkg::*;

   logic [XLEN-1:0] sh;

   assign sh = XLEN'(win >> {ofs, 3'b000});

   always_comb begin
      data = sh;
      unique case (len)
         LEN_B: data = uns ? XLEN'(sh[7:0])
                           : XLEN'($signed(sh[7:0]));
         LEN_H: data = uns ? XLEN'(sh[15:0])
                           : XLEN'($signed(sh[15:0]));
         LEN_W: data = uns ? XLEN'(sh[31:0])
                           : XLEN'($signed(sh[31:0]));
         LEN_D: data = sh;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Execute-stage load/store controller with ready handshake and
// two-beat word-crossing splits. LSU_MISALIGN_TRAP_EN traps instead.
module lsu_ctrl #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_W-1:0]    in_addr,
   input  logic [XLEN-1:0]      in_data,
   input  logic [1:0]           len,
   input  logic                 uns,
   input  logic                 load,
   input  logic                 store,
   output logic                 mem_req,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [XLEN-1:0]      mem_w_data,
   output logic [XLEN/8-1:0]    mem_we,
   input  logic                 mem_ready,
   input  logic [XLEN-1:0]      mem_r_data,
   output logic [XLEN-1:0]      ld_data,
   output logic                 ld_valid,
   output logic                 stall,
   output logic                 misalign
);
   import lsu_pkg::*;

   localparam int BYTES = XLEN / 8;
   localparam int OFS_W = $clog2(BYTES);

   localparam logic [0:0] IDLE   = S_IDLE;
   localparam logic [0:0] SECOND = S_SECOND;

   logic [OFS_W-1:0]   ofs;
   logic [1:0]         eff_len;
   logic [3:0]         size;
   logic [ADDR_W-1:0]  aligned;
   logic [2*BYTES-1:0] mask2;
   logic [2*XLEN-1:0]  shifted;
   logic               act;
   logic               mis;
   logic               split;
   logic               in_second;
   logic               acc;
   logic               fin_ld;

   logic [ADDR_W-1:0]  sec_addr;
   logic [BYTES-1:0]   sec_we;
   logic [XLEN-1:0]    sec_wdata;
   logic [OFS_W-1:0]   sec_ofs;
   logic [1:0]         sec_len;
   logic               sec_uns;
   logic               sec_load;
   logic [XLEN-1:0]    lo_win;

   logic               rsp_valid;
   logic [OFS_W-1:0]   rsp_ofs;
   logic [1:0]         rsp_len;
   logic               rsp_uns;
   logic               rsp_split;
   logic [2*XLEN-1:0]  win;
   logic [XLEN-1:0]    fmt_data;

   assign ofs     = in_addr[OFS_W-1:0];
   assign eff_len = (XLEN == 32 && len == LEN_D) ? LEN_W : len;
   assign size    = 4'd1 << eff_len;
   assign aligned = {in_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
   assign mask2   = (2*BYTES)'(byte_mask(3'(ofs), eff_len));
   assign shifted = {{XLEN{1'b0}}, in_data} << {ofs, 3'b000};
   assign act     = (load | store) & ~rst;

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis       = act & (|(4'(ofs) & (size - 4'd1)));
   assign split     = 1'b0;
   assign in_second = 1'b0;
   assign sec_addr  = '0;
   assign sec_we    = '0;
   assign sec_wdata = '0;
   assign sec_ofs   = '0;
   assign sec_len   = LEN_B;
   assign sec_uns   = 1'b0;
   assign sec_load  = 1'b0;
   assign lo_win    = '0;
`else
   logic [0:0]        state;
   logic [ADDR_W-1:0] a_addr;
   logic [BYTES-1:0]  hi_we;
   logic [XLEN-1:0]   hi_wdata;
   logic [XLEN-1:0]   lo_buf;
   logic [OFS_W-1:0]  r_ofs;
   logic [1:0]        r_len;
   logic              r_uns;
   logic              r_load;
   logic              cap;

   assign mis       = 1'b0;
   assign split     = (5'(ofs) + 5'(size)) > 5'(BYTES);
   assign in_second = (state == SECOND);
   assign sec_addr  = a_addr + ADDR_W'(BYTES);
   assign sec_we    = hi_we;
   assign sec_wdata = hi_wdata;
   assign sec_ofs   = r_ofs;
   assign sec_len   = r_len;
   assign sec_uns   = r_uns;
   assign sec_load  = r_load;
   assign lo_win    = lo_buf;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_addr   <= '0;
         hi_we    <= '0;
         hi_wdata <= '0;
         r_ofs    <= '0;
         r_len    <= LEN_B;
         r_uns    <= 1'b0;
         r_load   <= 1'b0;
         cap      <= 1'b0;
         lo_buf   <= '0;
      end else begin
         cap <= 1'b0;
         // Beat-1 read data is only on the bus for one cycle.
         if (cap) lo_buf <= mem_r_data;
         unique case (state)
            IDLE: begin
               if (acc && split) begin
                  state    <= SECOND;
                  a_addr   <= aligned;
                  hi_we    <= load ? '0 : mask2[2*BYTES-1:BYTES];
                  hi_wdata <= shifted[2*XLEN-1:XLEN];
                  r_ofs    <= ofs;
                  r_len    <= eff_len;
                  r_uns    <= uns;
                  r_load   <= load;
                  cap      <= load;
               end
            end
            SECOND: begin
               if (acc) state <= IDLE;
            end
         endcase
      end
   end
`endif

   always_comb begin
      mem_req    = 1'b0;
      mem_addr   = '0;
      mem_we     = '0;
      mem_w_data = '0;
      stall      = 1'b0;
      unique case (1'b1)
         in_second: begin
            mem_req    = ~rst;
            mem_addr   = sec_addr;
            mem_we     = sec_load ? '0 : sec_we;
            mem_w_data = sec_wdata;
            stall      = ~rst & ~mem_ready;
         end
         (~in_second & act & ~mis): begin
            mem_req    = 1'b1;
            mem_addr   = aligned;
            mem_we     = load ? '0 : mask2[BYTES-1:0];
            mem_w_data = shifted[XLEN-1:0];
            stall      = split | ~mem_ready;
         end
         default: ;
      endcase
   end

   assign acc      = mem_req & mem_ready;
   assign fin_ld   = acc & (in_second ? sec_load : (load & ~split));
   assign misalign = mis;

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_ofs   <= '0;
         rsp_len   <= LEN_B;
         rsp_uns   <= 1'b0;
         rsp_split <= 1'b0;
      end else begin
         rsp_valid <= fin_ld;
         if (fin_ld) begin
            rsp_ofs   <= in_second ? sec_ofs : ofs;
            rsp_len   <= in_second ? sec_len : eff_len;
            rsp_uns   <= in_second ? sec_uns : uns;
            rsp_split <= in_second;
         end
      end
   end

   assign win = rsp_split ? {mem_r_data, lo_win}
                          : {{XLEN{1'b0}}, mem_r_data};

   lsu_rdata_fmt #(
      .XLEN  (XLEN),
      .OFS_W (OFS_W)
   ) u_fmt (
      .win  (win),
      .ofs  (rsp_ofs),
      .len  (rsp_len),
      .uns  (rsp_uns),
      .data (fmt_data)
   );

   assign ld_valid = rsp_valid;
   assign ld_data  = rsp_valid ? fmt_data : '0;

endmodule
